// File: rtl/pc_sequencer_if.sv
// Bus between the PC sequencer and its decode/step logic.
// The sequencer takes the slave modport; decode and the bench drive the master.
interface pc_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             advance;
  logic             stall;
  logic             branch;
  logic             zero;
  logic             jump;
  logic             eret;
  logic [15:0]      branch_offset;
  logic [25:0]      jump_index;
  logic             interrupt;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_next_seq;
  logic [WIDTH-1:0] epc;
  logic             in_isr;
  logic             int_pending;
  logic             int_ack;

  modport master (
    output advance, stall, branch, zero, jump, eret, branch_offset, jump_index, interrupt,
    input  pc, pc_next_seq, epc, in_isr, int_pending, int_ack
  );

  modport slave (
    input  advance, stall, branch, zero, jump, eret, branch_offset, jump_index, interrupt,
    output pc, pc_next_seq, epc, in_isr, int_pending, int_ack
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: next-PC select, step/stall gating and a single-level
// vectored interrupt with saved return address.
//
// state  | meaning
// ST_RUN | normal flow; a pending request is taken on the next update
// ST_ISR | servicing an interrupt; eret returns to epc, new requests wait
module pc_sequencer #(
  parameter int               WIDTH        = 32,
  parameter bit               BYTE_ADDR    = 1'b0,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] INT_VECTOR   = WIDTH'('h80)
) (
  input logic           clock,
  input logic           reset,
  pc_sequencer_if.slave bus
);

  localparam int               SH  = BYTE_ADDR ? 2 : 0;
  localparam logic [WIDTH-1:0] INC = BYTE_ADDR ? WIDTH'(4) : WIDTH'(1);
  // Bits of the sequential PC that a jump keeps (the region above the index field).
  localparam logic [WIDTH-1:0] JMP_KEEP = ~((WIDTH'(1) << (26 + SH)) - WIDTH'(1));

  typedef enum logic {ST_RUN, ST_ISR} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic             pend_q, pend_d;
  logic             ack_q;
  logic [2:0]       sync_q;
  logic             rise;
  logic             adv;
  logic             take_int;
  logic [WIDTH-1:0] seq_pc;
  logic [WIDTH-1:0] off_ext;
  logic [WIDTH-1:0] branch_tgt;
  logic [WIDTH-1:0] jump_tgt;
  logic [WIDTH-1:0] flow_next;

  assign adv        = bus.advance & ~bus.stall;
  assign rise       = sync_q[1] & ~sync_q[2];
  assign seq_pc     = pc_q + INC;
  assign off_ext    = {{(WIDTH-16){bus.branch_offset[15]}}, bus.branch_offset};
  assign branch_tgt = seq_pc + (off_ext << SH);
  assign jump_tgt   = (seq_pc & JMP_KEEP) | (WIDTH'(bus.jump_index) << SH);

  // Address this instruction produces when no interrupt or return intervenes.
  assign flow_next = bus.jump                ? jump_tgt   :
                     (bus.branch & bus.zero) ? branch_tgt : seq_pc;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_VECTOR;
      epc_q   <= '0;
      pend_q  <= 1'b0;
      ack_q   <= 1'b0;
      sync_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      pend_q  <= pend_d;
      ack_q   <= take_int;
      sync_q  <= {sync_q[1:0], bus.interrupt};
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    epc_d    = epc_q;
    take_int = 1'b0;
    if (adv) begin
      unique case (state_q)
        ST_RUN: begin
          if (pend_q) begin
            take_int = 1'b1;
            pc_d     = INT_VECTOR;
            epc_d    = flow_next;
            state_d  = ST_ISR;
          end else begin
            pc_d = flow_next;
          end
        end
        ST_ISR: begin
          if (bus.eret) begin
            pc_d    = epc_q;
            state_d = ST_RUN;
          end else begin
            pc_d = flow_next;
          end
        end
      endcase
    end
    // A fresh edge arriving on the entry cycle must survive the clear.
    pend_d = rise | (pend_q & ~take_int);
  end

  assign bus.pc          = pc_q;
  assign bus.pc_next_seq = seq_pc;
  assign bus.epc         = epc_q;
  assign bus.in_isr      = (state_q == ST_ISR);
  assign bus.int_pending = pend_q;
  assign bus.int_ack     = ack_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: a word-mode and a byte-mode instance checked every cycle
// against an arithmetic reference model, plus hand-computed points along the way.
module tb_pc_sequencer;

  localparam longint MOD = 64'h1_0000_0000;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clock = ~clock;

  pc_sequencer_if #(.WIDTH(32)) u_w ();
  pc_sequencer_if #(.WIDTH(32)) u_b ();

  pc_sequencer #(.WIDTH(32), .BYTE_ADDR(1'b0), .RESET_VECTOR(32'h0),
                 .INT_VECTOR(32'h80)) dut_w (.clock(clock), .reset(rst_n), .bus(u_w.slave));
  pc_sequencer #(.WIDTH(32), .BYTE_ADDR(1'b1), .RESET_VECTOR(32'h0),
                 .INT_VECTOR(32'hF000_0010)) dut_b (.clock(clock), .reset(rst_n), .bus(u_b.slave));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: index 0 = word mode, 1 = byte mode.
  longint     m_pc[2];
  longint     m_epc[2];
  bit         m_isr[2];
  bit         m_pend[2];
  bit         m_ack[2];
  logic [2:0] m_hist[2];   // interrupt samples, [0] most recent

  task automatic model_edge(input int i, input logic adv, stall, br, z, jmp, er, irq,
                            input logic [15:0] off, input logic [25:0] idx,
                            output longint npc, output longint nepc, output bit nisr,
                            output bit npend, output bit nack, output logic [2:0] nhist);
    longint scale, seq, bt, jt, blk, dest, vec;
    bit go, take, rise;
    scale = (i == 1) ? 4 : 1;
    vec   = (i == 1) ? 64'hF000_0010 : 64'h80;
    seq   = (m_pc[i] + scale) % MOD;
    bt    = ((seq + longint'($signed(off)) * scale) % MOD + MOD) % MOD;
    blk   = 64'h400_0000 * scale;
    jt    = (seq / blk) * blk + longint'(idx) * scale;
    dest  = jmp ? jt : ((br && z) ? bt : seq);
    go    = adv && !stall;
    take  = go && m_pend[i] && !m_isr[i];
    // An edge on the pin shows up as a request three clock edges later.
    rise  = m_hist[i][1] && !m_hist[i][2];
    npc   = m_pc[i];
    nepc  = m_epc[i];
    nisr  = m_isr[i];
    if (take) begin
      npc  = vec;
      nepc = dest;
      nisr = 1'b1;
    end else if (go && er && m_isr[i]) begin
      npc  = m_epc[i];
      nisr = 1'b0;
    end else if (go) begin
      npc = dest;
    end
    npend = rise || (m_pend[i] && !take);
    nack  = take;
    nhist = {m_hist[i][1:0], irq};
  endtask

  always @(posedge clock or negedge rst_n) begin
    longint p0, e0, p1, e1;
    bit i0, q0, a0, i1, q1, a1;
    logic [2:0] h0, h1;
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_pc[i]   <= 0;
        m_epc[i]  <= 0;
        m_isr[i]  <= 1'b0;
        m_pend[i] <= 1'b0;
        m_ack[i]  <= 1'b0;
        m_hist[i] <= '0;
      end
    end else begin
      model_edge(0, u_w.advance, u_w.stall, u_w.branch, u_w.zero, u_w.jump, u_w.eret,
                 u_w.interrupt, u_w.branch_offset, u_w.jump_index, p0, e0, i0, q0, a0, h0);
      model_edge(1, u_b.advance, u_b.stall, u_b.branch, u_b.zero, u_b.jump, u_b.eret,
                 u_b.interrupt, u_b.branch_offset, u_b.jump_index, p1, e1, i1, q1, a1, h1);
      m_pc[0] <= p0; m_epc[0] <= e0; m_isr[0] <= i0; m_pend[0] <= q0; m_ack[0] <= a0; m_hist[0] <= h0;
      m_pc[1] <= p1; m_epc[1] <= e1; m_isr[1] <= i1; m_pend[1] <= q1; m_ack[1] <= a1; m_hist[1] <= h1;
    end
  end

  always @(negedge clock) begin
    chk("w.pc",      64'(u_w.pc),          m_pc[0]);
    chk("w.seq",     64'(u_w.pc_next_seq), (m_pc[0] + 1) % MOD);
    chk("w.epc",     64'(u_w.epc),         m_epc[0]);
    chk("w.in_isr",  64'(u_w.in_isr),      64'(m_isr[0]));
    chk("w.pending", 64'(u_w.int_pending), 64'(m_pend[0]));
    chk("w.ack",     64'(u_w.int_ack),     64'(m_ack[0]));
    chk("b.pc",      64'(u_b.pc),          m_pc[1]);
    chk("b.seq",     64'(u_b.pc_next_seq), (m_pc[1] + 4) % MOD);
    chk("b.epc",     64'(u_b.epc),         m_epc[1]);
    chk("b.in_isr",  64'(u_b.in_isr),      64'(m_isr[1]));
    chk("b.pending", 64'(u_b.int_pending), 64'(m_pend[1]));
    chk("b.ack",     64'(u_b.int_ack),     64'(m_ack[1]));
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic clr_w();
    u_w.branch = 1'b0; u_w.zero = 1'b0; u_w.jump = 1'b0; u_w.eret = 1'b0;
    u_w.branch_offset = '0; u_w.jump_index = '0;
  endtask

  task automatic clr_b();
    u_b.branch = 1'b0; u_b.zero = 1'b0; u_b.jump = 1'b0; u_b.eret = 1'b0;
    u_b.branch_offset = '0; u_b.jump_index = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clr_w(); clr_b();
    u_w.advance = 1'b0; u_w.stall = 1'b0; u_w.interrupt = 1'b0;
    u_b.advance = 1'b0; u_b.stall = 1'b0; u_b.interrupt = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    chk("rst.pc", 64'(u_w.pc), 64'h0);
    chk("rst.epc", 64'(u_w.epc), 64'h0);
    chk("rst.isr", 64'(u_w.in_isr), 64'h0);
    chk("rst.ack", 64'(u_w.int_ack), 64'h0);

    // sequential word mode
    u_w.advance = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      tick();
      chk("w.seq_run", 64'(u_w.pc), 64'(n));
    end
    // branch taken backwards, not taken, and jump beating branch
    u_w.branch = 1'b1; u_w.zero = 1'b1; u_w.branch_offset = 16'hFFFE;
    tick(); chk("w.br_taken", 64'(u_w.pc), 64'h7);
    u_w.branch = 1'b0;
    tick(); chk("w.pc8", 64'(u_w.pc), 64'h8);
    u_w.branch = 1'b1; u_w.zero = 1'b0;
    tick(); chk("w.br_not", 64'(u_w.pc), 64'h9);
    u_w.zero = 1'b1; u_w.jump = 1'b1; u_w.jump_index = 26'h40;
    tick(); chk("w.jump_wins", 64'(u_w.pc), 64'h40);
    clr_w();

    // single-step pulses every third cycle
    for (int r = 0; r < 3; r++) begin
      u_w.advance = 1'b1;
      tick(); chk("w.step", 64'(u_w.pc), 64'h41 + 64'(r));
      u_w.advance = 1'b0;
      tick(); chk("w.hold1", 64'(u_w.pc), 64'h41 + 64'(r));
      tick(); chk("w.hold2", 64'(u_w.pc), 64'h41 + 64'(r));
    end

    // wrap-around
    u_w.advance = 1'b1; u_w.jump = 1'b1; u_w.jump_index = 26'h0;
    tick(); chk("w.jmp0", 64'(u_w.pc), 64'h0);
    clr_w(); u_w.branch = 1'b1; u_w.zero = 1'b1; u_w.branch_offset = 16'hFFFE;
    tick(); chk("w.to_max", 64'(u_w.pc), 64'hFFFF_FFFF);
    u_w.branch = 1'b0;
    tick(); chk("w.wrap_seq", 64'(u_w.pc), 64'h0);
    u_w.branch = 1'b1; u_w.branch_offset = 16'hFFFD;
    tick(); chk("w.to_max1", 64'(u_w.pc), 64'hFFFF_FFFE);
    u_w.branch_offset = 16'h0001;
    tick(); chk("w.wrap_br", 64'(u_w.pc), 64'h0);
    clr_w();

    // interrupt entry and return
    u_w.jump = 1'b1; u_w.jump_index = 26'h5;
    tick(); chk("w.pc5", 64'(u_w.pc), 64'h5);
    clr_w(); u_w.advance = 1'b0; u_w.interrupt = 1'b1;
    tick(); chk("w.pend_k", 64'(u_w.int_pending), 64'h0);
    tick(); chk("w.pend_k1", 64'(u_w.int_pending), 64'h0);
    tick(); chk("w.pend_k2", 64'(u_w.int_pending), 64'h1);
    u_w.advance = 1'b1;
    tick();
    chk("w.ent_pc", 64'(u_w.pc), 64'h80);
    chk("w.ent_epc", 64'(u_w.epc), 64'h6);
    chk("w.ent_ack", 64'(u_w.int_ack), 64'h1);
    chk("w.ent_isr", 64'(u_w.in_isr), 64'h1);
    tick(); chk("w.ack_drop", 64'(u_w.int_ack), 64'h0);
    tick(); chk("w.pc82", 64'(u_w.pc), 64'h82);
    u_w.eret = 1'b1;
    tick();
    chk("w.ret_pc", 64'(u_w.pc), 64'h6);
    chk("w.ret_isr", 64'(u_w.in_isr), 64'h0);
    chk("w.level_once", 64'(u_w.int_pending), 64'h0);

    // eret outside an ISR is sequential
    u_w.interrupt = 1'b0;
    tick(); chk("w.eret_noop", 64'(u_w.pc), 64'h7);
    u_w.eret = 1'b0; u_w.advance = 1'b0;
    tick();

    // stall freezes update and entry
    u_w.stall = 1'b1; u_w.advance = 1'b1; u_w.interrupt = 1'b1;
    for (int n = 0; n < 4; n++) begin
      tick();
      chk("w.stall_pc", 64'(u_w.pc), 64'h7);
      chk("w.stall_ack", 64'(u_w.int_ack), 64'h0);
    end
    chk("w.stall_pend", 64'(u_w.int_pending), 64'h1);
    u_w.stall = 1'b0;
    tick();
    chk("w.ent2_pc", 64'(u_w.pc), 64'h80);
    chk("w.ent2_epc", 64'(u_w.epc), 64'h8);

    // second request during the ISR waits for eret
    u_w.interrupt = 1'b0;
    tick(); tick();
    u_w.interrupt = 1'b1;
    tick(); tick(); tick();
    chk("w.isr_pend", 64'(u_w.int_pending), 64'h1);
    chk("w.isr_nonest", 64'(u_w.pc), 64'h85);
    u_w.eret = 1'b1;
    tick();
    chk("w.ret2_pc", 64'(u_w.pc), 64'h8);
    chk("w.ret2_pend", 64'(u_w.int_pending), 64'h1);
    u_w.eret = 1'b0;
    tick();
    chk("w.ent3_pc", 64'(u_w.pc), 64'h80);
    chk("w.ent3_epc", 64'(u_w.epc), 64'h9);

    // rise arriving on the entry edge keeps pending set
    u_w.interrupt = 1'b0; u_w.eret = 1'b1;
    tick(); chk("w.ret3_pc", 64'(u_w.pc), 64'h9);
    u_w.eret = 1'b0; u_w.advance = 1'b0;
    tick(); tick();
    u_w.interrupt = 1'b1; tick();
    u_w.interrupt = 1'b0; tick();
    tick(); chk("w.pend_a", 64'(u_w.int_pending), 64'h1);
    u_w.interrupt = 1'b1; tick();
    tick();
    u_w.advance = 1'b1;
    tick();
    chk("w.coinc_pc", 64'(u_w.pc), 64'h80);
    chk("w.coinc_ack", 64'(u_w.int_ack), 64'h1);
    chk("w.coinc_pend", 64'(u_w.int_pending), 64'h1);
    chk("w.coinc_epc", 64'(u_w.epc), 64'hA);

    // asynchronous reset mid-ISR
    u_w.advance = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst.pc", 64'(u_w.pc), 64'h0);
    chk("arst.epc", 64'(u_w.epc), 64'h0);
    chk("arst.isr", 64'(u_w.in_isr), 64'h0);
    chk("arst.pend", 64'(u_w.int_pending), 64'h0);
    chk("arst.ack", 64'(u_w.int_ack), 64'h0);
    tick();
    rst_n = 1'b1;
    u_w.interrupt = 1'b0;

    // byte mode
    u_b.advance = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      tick();
      chk("b.seq_run", 64'(u_b.pc), 64'(4 * n));
    end
    u_b.advance = 1'b0; u_b.interrupt = 1'b1;
    tick(); tick(); tick();
    chk("b.pend", 64'(u_b.int_pending), 64'h1);
    u_b.advance = 1'b1;
    tick();
    chk("b.ent_pc", 64'(u_b.pc), 64'hF000_0010);
    chk("b.ent_epc", 64'(u_b.epc), 64'h14);
    u_b.jump = 1'b1; u_b.jump_index = 26'h1;
    tick(); chk("b.jump", 64'(u_b.pc), 64'hF000_0004);
    clr_b(); u_b.eret = 1'b1;
    tick(); chk("b.ret_pc", 64'(u_b.pc), 64'h14);
    clr_b(); u_b.branch = 1'b1; u_b.zero = 1'b1; u_b.branch_offset = 16'hFFFE;
    tick(); chk("b.branch", 64'(u_b.pc), 64'h10);
    clr_b(); u_b.advance = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
